// File: rtl/packet_fold_engine.sv
// ---------------------------------------------------------------------------
// packet_fold_engine
//
// Streams packets of L beats. The first K beats (head) are stored in a fold
// buffer and passed through. The middle beats (body) are passed through. Each
// of the last K beats (tail) is combined with the matching head beat, by add
// (DATA_WIDTH+1 bit sum) or by xor. Config is captured on each packet's
// first beat. Short packets (early tlast) and long packets (no tlast at beat
// L-1) are reported on err_len. Long packets have their excess beats dropped.
// An invalid K is reported on err_cfg and the packet is passed through
// unfolded.
//
// Optional build macro: PACKET_FOLD_STATS_EN adds the pkt_count/err_count
// statistics outputs.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cfg_len, cfg_k        packet length L and fold length K, in beats
//   cfg_mode              fold operator: 0 = add, 1 = xor
//   s_axis_*              input stream (DATA_WIDTH data)
//   m_axis_*              output stream (DATA_WIDTH+1 data), one register stage
//   err_len, err_cfg      single-cycle error pulses
//   pkt_count, err_count  (stats build only) completed packets, saturating
//                         error-pulse count
// ---------------------------------------------------------------------------
module packet_fold_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_K      = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [LEN_WIDTH-1:0]  cfg_k,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  err_len,
  output logic                  err_cfg
`ifdef PACKET_FOLD_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [15:0]           err_count
`endif
);

  localparam int KW  = $clog2(MAX_K);
  localparam int LW1 = LEN_WIDTH + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_BODY = 3'd2;
  localparam logic [2:0] ST_TAIL = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  // Combine a tail beat with its stored head beat.
  function automatic logic [DATA_WIDTH:0] fold_beat(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  xor_mode
  );
    logic [DATA_WIDTH:0] r;
    if (xor_mode) begin
      r = {1'b0, a ^ b};
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  logic [2:0]            state_r;
  logic [LEN_WIDTH-1:0]  idx_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  k_r;
  logic                  mode_r;
  logic [DATA_WIDTH:0]   m_data_r;
  logic                  m_valid_r;
  logic                  m_last_r;
  logic                  err_len_r;
  logic                  err_cfg_r;
  logic [DATA_WIDTH-1:0] fold_buf_r [MAX_K];

  logic                  acc_s;
  logic                  first_s;
  logic                  cfg_ok_s;
  logic [LEN_WIDTH-1:0]  len_s;
  logic [LEN_WIDTH-1:0]  k_s;
  logic                  mode_s;
  logic [LEN_WIDTH-1:0]  idx_s;
  logic [LEN_WIDTH-1:0]  body_end_s;
  logic [LEN_WIDTH-1:0]  nidx_s;
  logic                  last_idx_s;
  logic                  head_s;
  logic                  tail_s;
  logic [KW-1:0]         wr_idx_s;
  logic [KW-1:0]         rd_idx_s;
  logic [DATA_WIDTH:0]   out_data_s;
  logic [2:0]            nstate_s;

  assign s_axis_tready = !m_valid_r || m_axis_tready;
  assign acc_s         = s_axis_tvalid && s_axis_tready;
  assign m_axis_tdata  = m_data_r;
  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tlast  = m_last_r;
  assign err_len       = err_len_r;
  assign err_cfg       = err_cfg_r;

  // Effective config for the current beat, beat classification and fold datapath.
  always_comb begin
    first_s  = (state_r == ST_IDLE);
    cfg_ok_s = (cfg_k != '0) && ({cfg_k, 1'b0} <= {1'b0, cfg_len}) &&
               (LW1'(cfg_k) <= LW1'(MAX_K));
    if (first_s) begin
      len_s  = cfg_len;
      k_s    = cfg_ok_s ? cfg_k : '0;
      mode_s = cfg_mode;
      idx_s  = '0;
    end else begin
      len_s  = len_r;
      k_s    = k_r;
      mode_s = mode_r;
      idx_s  = idx_r;
    end
    body_end_s = len_s - k_s;
    nidx_s     = idx_s + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    // ">=" rather than "==" so that L=0 also ends on its first beat.
    last_idx_s = ({1'b0, idx_s} + {{LEN_WIDTH{1'b0}}, 1'b1}) >= {1'b0, len_s};

    case (state_r)
      ST_IDLE: begin head_s = (k_s != '0); tail_s = 1'b0; end
      ST_HEAD: begin head_s = 1'b1;        tail_s = 1'b0; end
      ST_BODY: begin head_s = 1'b0;        tail_s = 1'b0; end
      ST_TAIL: begin head_s = 1'b0;        tail_s = 1'b1; end
      default: begin head_s = 1'b0;        tail_s = 1'b0; end
    endcase

    wr_idx_s = KW'(idx_s);
    rd_idx_s = KW'(idx_s - body_end_s);
    if (tail_s) begin
      out_data_s = fold_beat(s_axis_tdata, fold_buf_r[rd_idx_s], mode_s);
    end else begin
      out_data_s = {1'b0, s_axis_tdata};
    end

    // Region of the next beat. With K=0 this never reaches TAIL.
    if (nidx_s < k_s) begin
      nstate_s = ST_HEAD;
    end else if (nidx_s < body_end_s) begin
      nstate_s = ST_BODY;
    end else begin
      nstate_s = ST_TAIL;
    end
  end

  // Store head beats. The buffer is not reset because a slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (acc_s && head_s) begin
      fold_buf_r[wr_idx_s] <= s_axis_tdata;
    end
  end

  // Packet FSM, config capture, output register and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      len_r     <= '0;
      k_r       <= '0;
      mode_r    <= 1'b0;
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      err_len_r <= 1'b0;
      err_cfg_r <= 1'b0;
    end else begin
      err_len_r <= 1'b0;
      err_cfg_r <= 1'b0;
      if (m_valid_r && m_axis_tready) begin
        m_valid_r <= 1'b0;
      end
      if (acc_s) begin
        if (state_r == ST_DROP) begin
          if (s_axis_tlast) begin
            state_r <= ST_IDLE;
          end
        end else begin
          m_valid_r <= 1'b1;
          m_data_r  <= out_data_s;
          m_last_r  <= s_axis_tlast || last_idx_s;
          if (first_s) begin
            len_r     <= len_s;
            k_r       <= k_s;
            mode_r    <= mode_s;
            err_cfg_r <= !cfg_ok_s;
          end
          if (s_axis_tlast) begin
            // Normal end, or an early end when the packet is short.
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            err_len_r <= !last_idx_s;
          end else if (last_idx_s) begin
            // Beat L-1 arrived without tlast: discard the rest of the packet.
            state_r   <= ST_DROP;
            idx_r     <= '0;
            err_len_r <= 1'b1;
          end else begin
            state_r <= nstate_s;
            idx_r   <= nidx_s;
          end
        end
      end
    end
  end

`ifdef PACKET_FOLD_STATS_EN
  logic [31:0] pkt_count_r;
  logic [15:0] err_count_r;

  assign pkt_count = pkt_count_r;
  assign err_count = err_count_r;

  // Count packets leaving the output and the error-pulse cycles (saturating).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_r <= 32'd0;
      err_count_r <= 16'd0;
    end else begin
      if (m_valid_r && m_axis_tready && m_last_r) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      if ((err_len_r || err_cfg_r) && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_fold_engine.sv
module tb_packet_fold_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_len = 16'd0;
  logic [15:0] cfg_k = 16'd0;
  logic        cfg_mode = 1'b0;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [8:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        err_len;
  logic        err_cfg;
`ifdef PACKET_FOLD_STATS_EN
  logic [31:0] pkt_count;
  logic [15:0] err_count;
`endif

  int n_total = 0;
  int n_bad = 0;
  int err_len_cnt = 0;
  int err_cfg_cnt = 0;
  int base_len = 0;
  int base_cfg = 0;
  int stall_cnt = 0;
  int hold_bad = 0;
  int obs_base = 0;
  bit rand_ready = 1'b0;
  bit have_held = 1'b0;
  logic [9:0] held = 10'd0;
  logic [9:0] obs_q [$];
  logic [9:0] exp_q [$];
  logic [7:0] pkt_d [32];
  int ex [16];

  packet_fold_engine dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_len       (cfg_len),
    .cfg_k         (cfg_k),
    .cfg_mode      (cfg_mode),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .err_len       (err_len),
    .err_cfg       (err_cfg)
`ifdef PACKET_FOLD_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Downstream ready: always high, or a coin toss per cycle when stalls are wanted.
  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: capture transfers, count error pulses, watch stalled data stays put.
  always @(negedge clk) begin
    if (reset) begin
      have_held = 1'b0;
    end else begin
      if (have_held && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} != held))) hold_bad++;
      if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
      have_held = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tlast, m_axis_tdata};
      if (err_len) err_len_cnt++;
      if (err_cfg) err_cfg_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int w;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_axis_tready && w < 1000) begin
      w++;
      stall_cnt++;
      @(negedge clk);
    end
    if (w >= 1000) check_eq("tready_wait", 32'(s_axis_tready), 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Send pkt_d[0..n-1], tlast on the final beat; config is scrambled after the first beat.
  task automatic send_pkt(input int n, input int len, input int k, input logic mode);
    cfg_len  = 16'(len);
    cfg_k    = 16'(k);
    cfg_mode = mode;
    for (int i = 0; i < n; i++) begin
      send_beat(pkt_d[i], i == n - 1);
      if (i == 0) begin
        cfg_len  = 16'd3;
        cfg_k    = 16'd1;
        cfg_mode = ~mode;
      end
    end
  endtask

  task automatic expect_ex(input int n, input int last_at);
    for (int i = 0; i < n; i++) exp_q.push_back({i == last_at, 9'(ex[i])});
  endtask

  task automatic mark();
    base_len = err_len_cnt;
    base_cfg = err_cfg_cnt;
  endtask

  task automatic check_errs(input string tag, input int n_len, input int n_cfg);
    check_eq({tag, "_err_len"}, 32'(err_len_cnt - base_len), 32'(n_len));
    check_eq({tag, "_err_cfg"}, 32'(err_cfg_cnt - base_cfg), 32'(n_cfg));
  endtask

  task automatic drain_check(input string tag);
    int w;
    w = 0;
    while ((obs_q.size() - obs_base) < exp_q.size() && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_count"}, 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (obs_base + i) < obs_q.size(); i++)
      check_eq(tag, 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    int sb;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_err_len", 32'(err_len), 32'd0);
    check_eq("rst_err_cfg", 32'(err_cfg), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_tready", 32'(s_axis_tready), 32'd1);

    // Add fold L=8 K=2 then xor fold L=6 K=2, back to back.
    mark();
    sb = stall_cnt;
    ex[0] = 1; ex[1] = 2; ex[2] = 3; ex[3] = 4; ex[4] = 5; ex[5] = 6; ex[6] = 8; ex[7] = 10;
    expect_ex(8, 7);
    ex[0] = 'h0F; ex[1] = 'hF0; ex[2] = 3; ex[3] = 4; ex[4] = 'hF0; ex[5] = 'hFF;
    expect_ex(6, 5);
    for (int i = 0; i < 8; i++) pkt_d[i] = 8'(i + 1);
    send_pkt(8, 8, 2, 1'b0);
    pkt_d[0] = 8'h0F; pkt_d[1] = 8'hF0; pkt_d[2] = 8'h03;
    pkt_d[3] = 8'h04; pkt_d[4] = 8'hFF; pkt_d[5] = 8'h0F;
    send_pkt(6, 6, 2, 1'b1);
    check_eq("b2b_stalls", 32'(stall_cnt - sb), 32'd0);
    drain_check("add_xor");
    check_errs("add_xor", 0, 0);

    // Add carry into bit 8: L=4 K=2.
    mark();
    pkt_d[0] = 8'hFF; pkt_d[1] = 8'h80; pkt_d[2] = 8'h01; pkt_d[3] = 8'h80;
    ex[0] = 'hFF; ex[1] = 'h80; ex[2] = 'h100; ex[3] = 'h100;
    expect_ex(4, 3);
    send_pkt(4, 4, 2, 1'b0);
    drain_check("carry");
    check_errs("carry", 0, 0);

    // Short packet: L=8, tlast on beat 5.
    mark();
    for (int i = 0; i < 10; i++) pkt_d[i] = 8'(i + 1);
    ex[0] = 1; ex[1] = 2; ex[2] = 3; ex[3] = 4; ex[4] = 5;
    expect_ex(5, 4);
    send_pkt(5, 8, 2, 1'b0);
    drain_check("short");
    check_errs("short", 1, 0);

    // Long packet: L=8, 10 beats; last two dropped.
    mark();
    ex[0] = 1; ex[1] = 2; ex[2] = 3; ex[3] = 4; ex[4] = 5; ex[5] = 6; ex[6] = 8; ex[7] = 10;
    expect_ex(8, 7);
    send_pkt(10, 8, 2, 1'b0);
    drain_check("long");
    check_errs("long", 1, 0);

    // K=5 with L=8 is invalid: plain pass-through.
    mark();
    for (int i = 0; i < 8; i++) ex[i] = i + 1;
    expect_ex(8, 7);
    send_pkt(8, 8, 5, 1'b0);
    drain_check("badk");
    check_errs("badk", 0, 1);

    // L=1: single unfolded beat with tlast.
    mark();
    pkt_d[0] = 8'h5A;
    ex[0] = 'h5A;
    expect_ex(1, 0);
    send_pkt(1, 1, 0, 1'b0);
    drain_check("len1");
    check_errs("len1", 0, 1);

    // Random downstream stalls: 1000 packets, L=16 K=4, add.
    rand_ready = 1'b1;
    mark();
    for (int p = 0; p < 1000; p++) begin
      for (int i = 0; i < 16; i++) begin
        pkt_d[i] = 8'($urandom);
        if (i < 12) exp_q.push_back({i == 15, 1'b0, pkt_d[i]});
        else exp_q.push_back({i == 15, {1'b0, pkt_d[i]} + {1'b0, pkt_d[i - 12]}});
      end
      send_pkt(16, 16, 4, 1'b0);
    end
    drain_check("rand");
    check_errs("rand", 0, 0);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a packet, then a clean packet.
    cfg_len = 16'd8; cfg_k = 16'd2; cfg_mode = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(8'(i + 1), 1'b0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("mid_rst_err_len", 32'(err_len), 32'd0);
    check_eq("mid_rst_err_cfg", 32'(err_cfg), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs_base = obs_q.size();
    exp_q.delete();
    mark();
    for (int i = 0; i < 8; i++) pkt_d[i] = 8'(i + 1);
    ex[0] = 1; ex[1] = 2; ex[2] = 3; ex[3] = 4; ex[4] = 5; ex[5] = 6; ex[6] = 8; ex[7] = 10;
    expect_ex(8, 7);
    send_pkt(8, 8, 2, 1'b0);
    drain_check("post_rst");
    check_errs("post_rst", 0, 0);
`ifdef PACKET_FOLD_STATS_EN
    check_eq("pkt_count", pkt_count, 32'd1);
    check_eq("err_count", 32'(err_count), 32'd0);
`endif

    check_eq("hold_stable", 32'(hold_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
